sram_bus_arbiter: RTL

//  Shares one SRAM-like bus (req/addr_ok/data_ok handshake) between the IF-stage

---
 rtl/sram_bus_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch port and the data port.
// One transaction in flight; data has priority, bounded by a starvation count.
module sram_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);

  state_t           r_state;
  logic             r_owner;
  logic [CNT_W-1:0] r_cnt;

  logic w_idle;
  logic w_starved;
  logic w_pick_data;
  logic w_sel;
  logic w_req;
  logic w_addr_ok;
  logic w_data_ok;

  assign w_idle      = (r_state == S_IDLE);
  assign w_starved   = (r_cnt == LIM);
  assign w_pick_data = data_req & (~inst_req | ~w_starved);
  // Owner is locked once granted; only IDLE re-arbitrates.
  assign w_sel       = w_idle ? w_pick_data : r_owner;

  always_comb begin
    w_req = 1'b0;
    unique case (r_state)
      S_IDLE:  w_req = inst_req | data_req;
      S_ADDR:  w_req = r_owner ? data_req : inst_req;
      default: w_req = 1'b0;
    endcase
  end

  assign w_addr_ok = mem_addr_ok & w_req;
  assign w_data_ok = (r_state == S_DATA) & mem_data_ok;

  assign mem_req   = resetn & w_req;
  assign mem_wr    = resetn & w_sel & data_wr;
  assign mem_size  = !resetn ? 2'd0  : (w_sel ? data_size : 2'd2);
  assign mem_wstrb = !resetn ? 4'h0  : (w_sel ? data_wstrb : 4'h0);
  assign mem_addr  = !resetn ? 32'd0 : (w_sel ? data_addr : inst_addr);
  assign mem_wdata = !resetn ? 32'd0 : (w_sel ? data_wdata : 32'd0);

  assign inst_addr_ok = resetn & w_addr_ok & ~w_sel;
  assign data_addr_ok = resetn & w_addr_ok & w_sel;
  assign inst_data_ok = resetn & w_data_ok & ~r_owner;
  assign data_data_ok = resetn & w_data_ok & r_owner;
  assign inst_rdata   = resetn ? mem_rdata : 32'd0;
  assign data_rdata   = resetn ? mem_rdata : 32'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (inst_req | data_req) begin
            r_owner <= w_pick_data;
            if (w_pick_data & inst_req)
              r_cnt <= w_starved ? r_cnt : r_cnt + CNT_W'(1);
            else
              r_cnt <= '0;
            r_state <= mem_addr_ok ? S_DATA : S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_addr_ok)
            r_state <= S_DATA;
        end
        S_DATA: begin
          if (mem_data_ok)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
